// File: rtl/soc_router_pkg.sv
// SoC router types: AXI4-Lite request/response structs, peripheral enum and default address map.
// Shared by soc_addr_decode and soc_axil_router.
package soc_router_pkg;

  localparam int unsigned AXIL_AW = 64;
  localparam int unsigned AXIL_DW = 64;
  localparam int unsigned AXIL_SW = AXIL_DW / 8;

  typedef enum logic [3:0] {
    DRAM     = 4'd0,
    GPIO     = 4'd1,
    ETHERNET = 4'd2,
    SPI      = 4'd3,
    UART     = 4'd4,
    PLIC     = 4'd5,
    CLINT    = 4'd6,
    ROM      = 4'd7,
    DEBUG    = 4'd8
  } axi_slaves_t;

  localparam int unsigned NB_PERIPHERALS = 9;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [AXIL_AW-1:0] base;
    logic [AXIL_AW-1:0] length;
  } addr_rule_t;

  // Concatenation lists the highest port first so index == port number.
  localparam addr_rule_t [NB_PERIPHERALS-1:0] DefaultMap = {
    addr_rule_t'{base: 64'h0000_0000, length: 64'h0000_1000},  // Debug
    addr_rule_t'{base: 64'h0001_0000, length: 64'h0001_0000},  // ROM
    addr_rule_t'{base: 64'h0200_0000, length: 64'h000C_0000},  // CLINT
    addr_rule_t'{base: 64'h0C00_0000, length: 64'h03FF_FFFF},  // PLIC
    addr_rule_t'{base: 64'h1000_0000, length: 64'h0000_1000},  // UART
    addr_rule_t'{base: 64'h2000_0000, length: 64'h0080_0000},  // SPI
    addr_rule_t'{base: 64'h3000_0000, length: 64'h0001_0000},  // Ethernet
    addr_rule_t'{base: 64'h0010_0000, length: 64'h0001_0000},  // GPIO
    addr_rule_t'{base: 64'h8000_0000, length: 64'h4000_0000}   // DRAM
  };

  typedef struct packed {
    logic               aw_valid;
    logic [AXIL_AW-1:0] aw_addr;
    logic               w_valid;
    logic [AXIL_DW-1:0] w_data;
    logic [AXIL_SW-1:0] w_strb;
    logic               b_ready;
    logic               ar_valid;
    logic [AXIL_AW-1:0] ar_addr;
    logic               r_ready;
  } axil_req_t;

  typedef struct packed {
    logic               aw_ready;
    logic               w_ready;
    logic               b_valid;
    logic [1:0]         b_resp;
    logic               ar_ready;
    logic               r_valid;
    logic [AXIL_DW-1:0] r_data;
    logic [1:0]         r_resp;
  } axil_resp_t;

  typedef enum logic [2:0] {
    W_IDLE, W_AW, W_W, W_B, W_ERR_W, W_ERR_B
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE, R_AR, R_R, R_ERR
  } rd_state_e;

endpackage

// File: rtl/soc_addr_decode.sv
// Combinational address decoder: lowest-index rule with base <= addr < base+length wins.
// Zero latency; no flow control.
module soc_addr_decode
  import soc_router_pkg::*;
#(
  parameter int unsigned NrSlaves  = NB_PERIPHERALS,
  parameter int unsigned AddrWidth = AXIL_AW,
  parameter int unsigned IdxW      = (NrSlaves > 1) ? $clog2(NrSlaves) : 1
) (
  input  logic [AddrWidth-1:0]       addr_i,
  input  addr_rule_t [NrSlaves-1:0]  map_i,
  output logic [IdxW-1:0]            idx_o,
  output logic                       dec_valid_o
);

  logic [AddrWidth:0] base;
  logic [AddrWidth:0] lim;

  // One extra bit keeps base+length from wrapping; scanning downward lets the lowest index win.
  always_comb begin
    idx_o       = '0;
    dec_valid_o = 1'b0;
    base        = '0;
    lim         = '0;
    for (int i = NrSlaves - 1; i >= 0; i--) begin
      base = {1'b0, map_i[i].base[AddrWidth-1:0]};
      lim  = base + {1'b0, map_i[i].length[AddrWidth-1:0]};
      if (({1'b0, addr_i} >= base) && ({1'b0, addr_i} < lim)) begin
        idx_o       = IdxW'(i);
        dec_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc_axil_router.sv
// AXI4-Lite 1:N router, one outstanding read and write; downstream aw/ar one cycle after accept, b/r pass through.
// Unmapped addresses answered with DECERR locally; optional SOC_AXIL_ROUTER_ERRLOG_EN adds DECERR count/address.
module soc_axil_router
  import soc_router_pkg::*;
#(
  parameter int unsigned AddrWidth = AXIL_AW,
  parameter int unsigned DataWidth = AXIL_DW,
  parameter int unsigned NrSlaves  = NB_PERIPHERALS,
  parameter addr_rule_t [NrSlaves-1:0] AddrMap = DefaultMap
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  axil_req_t                  slv_req_i,
  output axil_resp_t                 slv_resp_o,
  output axil_req_t  [NrSlaves-1:0]  mst_req_o,
  input  axil_resp_t [NrSlaves-1:0]  mst_resp_i
`ifdef SOC_AXIL_ROUTER_ERRLOG_EN
  ,
  output logic [31:0]                decerr_cnt_o,
  output logic [AddrWidth-1:0]       decerr_addr_o
`endif
);

  localparam int unsigned IdxW = (NrSlaves > 1) ? $clog2(NrSlaves) : 1;
  localparam logic [DataWidth-1:0] RDataErr = '0;

  wr_state_e             wstate_q, wstate_d;
  rd_state_e             rstate_q, rstate_d;
  logic [AddrWidth-1:0]  waddr_q, waddr_d, raddr_q, raddr_d;
  logic [IdxW-1:0]       widx_q, widx_d, ridx_q, ridx_d;
  logic                  aw_ready_q, aw_ready_d, ar_ready_q, ar_ready_d;
  logic [IdxW-1:0]       aw_idx, ar_idx;
  logic                  aw_hit, ar_hit;

  soc_addr_decode #(.NrSlaves(NrSlaves), .AddrWidth(AddrWidth), .IdxW(IdxW)) u_aw_dec (
    .addr_i      (slv_req_i.aw_addr),
    .map_i       (AddrMap),
    .idx_o       (aw_idx),
    .dec_valid_o (aw_hit)
  );

  soc_addr_decode #(.NrSlaves(NrSlaves), .AddrWidth(AddrWidth), .IdxW(IdxW)) u_ar_dec (
    .addr_i      (slv_req_i.ar_addr),
    .map_i       (AddrMap),
    .idx_o       (ar_idx),
    .dec_valid_o (ar_hit)
  );

  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    widx_d   = widx_q;
    case (wstate_q)
      W_IDLE: if (aw_ready_q && slv_req_i.aw_valid) begin
        waddr_d  = slv_req_i.aw_addr;
        widx_d   = aw_idx;
        wstate_d = aw_hit ? W_AW : W_ERR_W;
      end
      W_AW:    if (mst_resp_i[widx_q].aw_ready) wstate_d = W_W;
      W_W:     if (slv_req_i.w_valid && mst_resp_i[widx_q].w_ready) wstate_d = W_B;
      W_B:     if (mst_resp_i[widx_q].b_valid && slv_req_i.b_ready) wstate_d = W_IDLE;
      W_ERR_W: if (slv_req_i.w_valid) wstate_d = W_ERR_B;
      W_ERR_B: if (slv_req_i.b_ready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
    aw_ready_d = (wstate_d == W_IDLE);
  end

  always_comb begin
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    ridx_d   = ridx_q;
    case (rstate_q)
      R_IDLE: if (ar_ready_q && slv_req_i.ar_valid) begin
        raddr_d  = slv_req_i.ar_addr;
        ridx_d   = ar_idx;
        rstate_d = ar_hit ? R_AR : R_ERR;
      end
      R_AR:    if (mst_resp_i[ridx_q].ar_ready) rstate_d = R_R;
      R_R:     if (mst_resp_i[ridx_q].r_valid && slv_req_i.r_ready) rstate_d = R_IDLE;
      R_ERR:   if (slv_req_i.r_ready) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
    ar_ready_d = (rstate_d == R_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wstate_q   <= W_IDLE;
      rstate_q   <= R_IDLE;
      waddr_q    <= '0;
      raddr_q    <= '0;
      widx_q     <= '0;
      ridx_q     <= '0;
      aw_ready_q <= 1'b0;
      ar_ready_q <= 1'b0;
    end else begin
      wstate_q   <= wstate_d;
      rstate_q   <= rstate_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      widx_q     <= widx_d;
      ridx_q     <= ridx_d;
      aw_ready_q <= aw_ready_d;
      ar_ready_q <= ar_ready_d;
    end
  end

  // Only the selected port ever sees a non-zero request; unselected b/r valids are never looked at.
  always_comb begin
    mst_req_o           = '0;
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_ready_q;
    slv_resp_o.ar_ready = ar_ready_q;
    case (wstate_q)
      W_AW: begin
        mst_req_o[widx_q].aw_valid = 1'b1;
        mst_req_o[widx_q].aw_addr  = waddr_q;
      end
      W_W: begin
        mst_req_o[widx_q].w_valid = slv_req_i.w_valid;
        mst_req_o[widx_q].w_data  = slv_req_i.w_data;
        mst_req_o[widx_q].w_strb  = slv_req_i.w_strb;
        slv_resp_o.w_ready        = mst_resp_i[widx_q].w_ready;
      end
      W_B: begin
        slv_resp_o.b_valid        = mst_resp_i[widx_q].b_valid;
        slv_resp_o.b_resp         = mst_resp_i[widx_q].b_resp;
        mst_req_o[widx_q].b_ready = slv_req_i.b_ready;
      end
      W_ERR_W: slv_resp_o.w_ready = 1'b1;
      W_ERR_B: begin
        slv_resp_o.b_valid = 1'b1;
        slv_resp_o.b_resp  = RESP_DECERR;
      end
      default: ;
    endcase
    case (rstate_q)
      R_AR: begin
        mst_req_o[ridx_q].ar_valid = 1'b1;
        mst_req_o[ridx_q].ar_addr  = raddr_q;
      end
      R_R: begin
        slv_resp_o.r_valid        = mst_resp_i[ridx_q].r_valid;
        slv_resp_o.r_data         = mst_resp_i[ridx_q].r_data;
        slv_resp_o.r_resp         = mst_resp_i[ridx_q].r_resp;
        mst_req_o[ridx_q].r_ready = slv_req_i.r_ready;
      end
      R_ERR: begin
        slv_resp_o.r_valid = 1'b1;
        slv_resp_o.r_data  = RDataErr;
        slv_resp_o.r_resp  = RESP_DECERR;
      end
      default: ;
    endcase
  end

`ifdef SOC_AXIL_ROUTER_ERRLOG_EN
  logic [31:0]          decerr_cnt_q, decerr_cnt_d;
  logic [AddrWidth-1:0] decerr_addr_q, decerr_addr_d;
  logic                 w_err_hs, r_err_hs;
  logic [32:0]          cnt_sum;

  // Read and write DECERRs can complete together, so the step is 0..2 before saturation.
  always_comb begin
    w_err_hs      = (wstate_q == W_ERR_B) && slv_req_i.b_ready;
    r_err_hs      = (rstate_q == R_ERR) && slv_req_i.r_ready;
    cnt_sum       = {1'b0, decerr_cnt_q} + {32'b0, w_err_hs} + {32'b0, r_err_hs};
    decerr_cnt_d  = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    decerr_addr_d = decerr_addr_q;
    if (r_err_hs) decerr_addr_d = raddr_q;
    if (w_err_hs) decerr_addr_d = waddr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      decerr_cnt_q  <= '0;
      decerr_addr_q <= '0;
    end else begin
      decerr_cnt_q  <= decerr_cnt_d;
      decerr_addr_q <= decerr_addr_d;
    end
  end

  assign decerr_cnt_o  = decerr_cnt_q;
  assign decerr_addr_o = decerr_addr_q;
`endif

endmodule
